// File: rtl/ps2_control_comandos_if.sv
// Scan-code byte input and decoded command/status outputs of the PS/2 command decoder.
// The master side drives bytes and acknowledges; the slave side is the decoder.
interface ps2_control_comandos_if;
    logic [7:0] dato;
    logic       tick;
    logic       cmd_ack;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_release;
    logic       inicio_tomadatos;
    logic       ocupado;
    logic       err_overrun;
    logic       err_timeout;

    modport master (
        output dato, tick, cmd_ack,
        input  cmd_valid, cmd_code, cmd_release, inicio_tomadatos,
               ocupado, err_overrun, err_timeout
    );

    modport slave (
        input  dato, tick, cmd_ack,
        output cmd_valid, cmd_code, cmd_release, inicio_tomadatos,
               ocupado, err_overrun, err_timeout
    );
endinterface

// File: rtl/ps2_control_comandos.sv
// PS/2 scan-code to navigation command decoder; command appears one cycle after the final byte.
// A command is held until cmd_ack; bytes arriving meanwhile are dropped and flagged as overrun.
module ps2_control_comandos #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_control_comandos_if.slave bus
);

    typedef enum logic [2:0] {IDLE, PRE_F0, PRE_E0, PRE_E0F0, HOLD} state_t;

    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E0 = 8'hE0;

    function automatic logic [2:0] map_normal(input logic [7:0] b);
        case (b)
            8'h1D:   map_normal = 3'd1;
            8'h1B:   map_normal = 3'd2;
            8'h1C:   map_normal = 3'd3;
            8'h23:   map_normal = 3'd4;
            8'h5A:   map_normal = 3'd5;
            8'h76:   map_normal = 3'd6;
            default: map_normal = 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] map_ext(input logic [7:0] b);
        case (b)
            8'h75:   map_ext = 3'd1;
            8'h72:   map_ext = 3'd2;
            8'h6B:   map_ext = 3'd3;
            8'h74:   map_ext = 3'd4;
            default: map_ext = 3'd0;
        endcase
    endfunction

    state_t      state_q, state_nxt;
    logic [15:0] timer_q, timer_nxt;
    logic [5:0]  pressed_q, pressed_nxt;
    logic [2:0]  code_q, code_nxt;
    logic        rel_q, rel_nxt;
    logic        inicio_q, inicio_nxt;
    logic        overrun_q, overrun_nxt;
    logic        timeout_q, timeout_nxt;

    logic        res_go;
    logic        res_brk;
    logic [2:0]  res_code;
    logic [5:0]  res_mask;
    logic        in_prefix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pressed_q <= '0;
            code_q    <= '0;
            rel_q     <= 1'b0;
            inicio_q  <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            timer_q   <= timer_nxt;
            pressed_q <= pressed_nxt;
            code_q    <= code_nxt;
            rel_q     <= rel_nxt;
            inicio_q  <= inicio_nxt;
            overrun_q <= overrun_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        timer_nxt   = timer_q;
        pressed_nxt = pressed_q;
        code_nxt    = code_q;
        rel_nxt     = rel_q;
        inicio_nxt  = 1'b0;
        overrun_nxt = overrun_q;
        timeout_nxt = 1'b0;
        res_go      = 1'b0;
        res_brk     = 1'b0;
        res_code    = 3'd0;
        res_mask    = 6'd0;
        in_prefix   = (state_q == PRE_F0) || (state_q == PRE_E0) || (state_q == PRE_E0F0);

        case (state_q)
            IDLE: begin
                if (bus.tick) begin
                    if (bus.dato == BYTE_F0) begin
                        state_nxt = PRE_F0;
                        timer_nxt = '0;
                    end else if (bus.dato == BYTE_E0) begin
                        state_nxt = PRE_E0;
                        timer_nxt = '0;
                    end else if (map_normal(bus.dato) != 3'd0) begin
                        res_go   = 1'b1;
                        res_code = map_normal(bus.dato);
                    end
                end
            end
            PRE_E0: begin
                if (bus.tick) begin
                    if (bus.dato == BYTE_F0) begin
                        state_nxt = PRE_E0F0;
                        timer_nxt = '0;
                    end else if (map_ext(bus.dato) != 3'd0) begin
                        res_go   = 1'b1;
                        res_code = map_ext(bus.dato);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            PRE_F0: begin
                if (bus.tick) begin
                    if (map_normal(bus.dato) != 3'd0) begin
                        res_go   = 1'b1;
                        res_brk  = 1'b1;
                        res_code = map_normal(bus.dato);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            PRE_E0F0: begin
                if (bus.tick) begin
                    if (map_ext(bus.dato) != 3'd0) begin
                        res_go   = 1'b1;
                        res_brk  = 1'b1;
                        res_code = map_ext(bus.dato);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            HOLD: begin
                // Bytes cannot be queued behind a pending command, even in the ack cycle.
                if (bus.tick) begin
                    overrun_nxt = 1'b1;
                end
                if (bus.cmd_ack) begin
                    state_nxt = IDLE;
                    code_nxt  = 3'd0;
                    rel_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A byte on the expiry cycle wins over the timeout.
        if (in_prefix && !bus.tick) begin
            if (timer_q == TIMEOUT_CYC - 16'd1) begin
                state_nxt   = IDLE;
                timer_nxt   = '0;
                timeout_nxt = 1'b1;
            end else begin
                timer_nxt = timer_q + 16'd1;
            end
        end

        if (res_go) begin
            res_mask  = 6'd1 << (res_code - 3'd1);
            state_nxt = IDLE;
            // Typematic repeats of a held key are swallowed; releases are always reported.
            if (res_brk || ((pressed_q & res_mask) == 6'd0)) begin
                state_nxt   = HOLD;
                code_nxt    = res_code;
                rel_nxt     = res_brk;
                pressed_nxt = res_brk ? (pressed_q & ~res_mask) : (pressed_q | res_mask);
                inicio_nxt  = !res_brk && (res_code == 3'd5);
            end
        end
    end

    assign bus.cmd_valid        = (state_q == HOLD);
    assign bus.cmd_code         = code_q;
    assign bus.cmd_release      = rel_q;
    assign bus.inicio_tomadatos = inicio_q;
    assign bus.ocupado          = (state_q != IDLE);
    assign bus.err_overrun      = overrun_q;
    assign bus.err_timeout      = timeout_q;

endmodule

// File: tb/tb_ps2_control_comandos.sv
// Bench for the PS/2 command decoder: vector table, corner sequences and a random byte stream
// compared against a byte-buffer model of the scan-code rules.
module tb_ps2_control_comandos;

    localparam logic [15:0] T = 16'd20;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ps2_control_comandos_if bus();

    ps2_control_comandos #(.TIMEOUT_CYC(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic       emit;
        logic [2:0] code;
        logic       rel;
        logic       ini;
    } vec_t;

    vec_t vecs[$];

    // Reference model: raw byte buffer plus pressed-key set.
    int          nmap[bit [7:0]];
    int          emap[bit [7:0]];
    logic [7:0]  mbuf[$];
    bit          mpress[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.dato = b;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        bus.dato = 8'h00;
    endtask

    task automatic do_ack();
        bus.cmd_ack = 1'b1;
        step();
        bus.cmd_ack = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        mbuf.delete();
        for (int i = 0; i < 7; i++) mpress[i] = 1'b0;
    endtask

    task automatic add_vec(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int n, input logic emit, input logic [2:0] code,
                           input logic rel, input logic ini);
        vec_t v;
        v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n;
        v.emit = emit; v.code = code; v.rel = rel; v.ini = ini;
        vecs.push_back(v);
    endtask

    task automatic model_byte(input logic [7:0] b, output bit emit, output int code, output bit rel);
        int n;
        bit ext, brk;
        mbuf.push_back(b);
        emit = 0; code = 0; rel = 0;
        n = mbuf.size();
        if ((n == 1 && (b == 8'hF0 || b == 8'hE0)) || (n == 2 && mbuf[0] == 8'hE0 && b == 8'hF0))
            return;
        ext = (n >= 2) && (mbuf[0] == 8'hE0);
        brk = (n >= 2) && (mbuf[n-2] == 8'hF0);
        if (ext) code = emap.exists(b) ? emap[b] : 0;
        else     code = nmap.exists(b) ? nmap[b] : 0;
        mbuf.delete();
        if (code == 0) return;
        if (!brk && mpress[code]) return;
        emit = 1;
        rel = brk;
        mpress[code] = !brk;
    endtask

    initial begin
        bit   m_emit, m_rel;
        int   m_code;
        logic [7:0] b;
        logic [2:0] held_code;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.dato = 8'h00;
        bus.tick = 1'b0;
        bus.cmd_ack = 1'b0;

        nmap[8'h1D] = 1; nmap[8'h1B] = 2; nmap[8'h1C] = 3;
        nmap[8'h23] = 4; nmap[8'h5A] = 5; nmap[8'h76] = 6;
        emap[8'h75] = 1; emap[8'h72] = 2; emap[8'h6B] = 3; emap[8'h74] = 4;

        step();
        chk("rst_valid",   32'(bus.cmd_valid), 0);
        chk("rst_code",    32'(bus.cmd_code), 0);
        chk("rst_release", 32'(bus.cmd_release), 0);
        chk("rst_inicio",  32'(bus.inicio_tomadatos), 0);
        chk("rst_ocupado", 32'(bus.ocupado), 0);
        chk("rst_overrun", 32'(bus.err_overrun), 0);
        chk("rst_timeout", 32'(bus.err_timeout), 0);
        rst = 1'b1;
        step();

        add_vec(8'h1D, 8'h00, 8'h00, 1, 1, 3'd1, 0, 0);
        add_vec(8'h1B, 8'h00, 8'h00, 1, 1, 3'd2, 0, 0);
        add_vec(8'h1C, 8'h00, 8'h00, 1, 1, 3'd3, 0, 0);
        add_vec(8'h23, 8'h00, 8'h00, 1, 1, 3'd4, 0, 0);
        add_vec(8'h5A, 8'h00, 8'h00, 1, 1, 3'd5, 0, 1);
        add_vec(8'h76, 8'h00, 8'h00, 1, 1, 3'd6, 0, 0);
        add_vec(8'hE0, 8'h75, 8'h00, 2, 1, 3'd1, 0, 0);
        add_vec(8'hE0, 8'h72, 8'h00, 2, 1, 3'd2, 0, 0);
        add_vec(8'hE0, 8'h6B, 8'h00, 2, 1, 3'd3, 0, 0);
        add_vec(8'hE0, 8'h74, 8'h00, 2, 1, 3'd4, 0, 0);
        add_vec(8'hF0, 8'h1D, 8'h00, 2, 1, 3'd1, 1, 0);
        add_vec(8'hF0, 8'h5A, 8'h00, 2, 1, 3'd5, 1, 0);
        add_vec(8'hE0, 8'hF0, 8'h74, 3, 1, 3'd4, 1, 0);
        add_vec(8'hE0, 8'hE0, 8'h1D, 3, 1, 3'd1, 0, 0);
        add_vec(8'hF0, 8'hF0, 8'h1D, 3, 1, 3'd1, 0, 0);
        add_vec(8'hE0, 8'h1D, 8'h00, 2, 0, 3'd0, 0, 0);
        add_vec(8'h55, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0);
        add_vec(8'hF0, 8'h75, 8'h00, 2, 0, 3'd0, 0, 0);
        add_vec(8'hE0, 8'hF0, 8'h1D, 3, 0, 3'd0, 0, 0);

        foreach (vecs[i]) begin
            do_reset();
            send(vecs[i].b0);
            if (vecs[i].n > 1) send(vecs[i].b1);
            if (vecs[i].n > 2) send(vecs[i].b2);
            chk($sformatf("vec%0d_valid", i), 32'(bus.cmd_valid), 32'(vecs[i].emit));
            if (vecs[i].emit) begin
                chk($sformatf("vec%0d_code", i), 32'(bus.cmd_code), 32'(vecs[i].code));
                chk($sformatf("vec%0d_rel", i),  32'(bus.cmd_release), 32'(vecs[i].rel));
                chk($sformatf("vec%0d_ini", i),  32'(bus.inicio_tomadatos), 32'(vecs[i].ini));
                step();
                chk($sformatf("vec%0d_ini_end", i), 32'(bus.inicio_tomadatos), 0);
                do_ack();
                chk($sformatf("vec%0d_acked", i), 32'(bus.cmd_valid), 0);
            end else begin
                chk($sformatf("vec%0d_ocupado", i), 32'(bus.ocupado), 0);
            end
        end

        // Make then break of the same key; a fresh make afterwards proves the bit cleared.
        do_reset();
        send(8'h1D);
        chk("mb_make_code", 32'(bus.cmd_code), 1);
        chk("mb_make_rel",  32'(bus.cmd_release), 0);
        do_ack();
        send(8'hF0);
        send(8'h1D);
        chk("mb_brk_valid", 32'(bus.cmd_valid), 1);
        chk("mb_brk_rel",   32'(bus.cmd_release), 1);
        do_ack();
        send(8'h1D);
        chk("mb_remake",    32'(bus.cmd_valid), 1);
        do_ack();
        send(8'h1D);
        chk("typematic",    32'(bus.cmd_valid), 0);
        chk("typematic_oc", 32'(bus.ocupado), 0);

        // Enter: one-cycle start pulse, command held while ack is low.
        do_reset();
        send(8'h5A);
        chk("ent_valid", 32'(bus.cmd_valid), 1);
        chk("ent_ini",   32'(bus.inicio_tomadatos), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ent_hold_valid", 32'(bus.cmd_valid), 1);
            chk("ent_hold_code",  32'(bus.cmd_code), 5);
            chk("ent_hold_ini",   32'(bus.inicio_tomadatos), 0);
        end
        do_ack();
        chk("ent_acked", 32'(bus.cmd_valid), 0);

        // Overrun: bytes during HOLD and in the ack cycle are dropped.
        do_reset();
        send(8'h1C);
        send(8'h23);
        chk("ovr_flag",  32'(bus.err_overrun), 1);
        chk("ovr_code",  32'(bus.cmd_code), 3);
        chk("ovr_valid", 32'(bus.cmd_valid), 1);
        bus.dato = 8'h1B; bus.tick = 1'b1; bus.cmd_ack = 1'b1;
        step();
        bus.tick = 1'b0; bus.cmd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ovr_drop_valid", 32'(bus.cmd_valid), 0);
            chk("ovr_sticky",     32'(bus.err_overrun), 1);
            step();
        end
        do_reset();
        chk("ovr_rst_clear", 32'(bus.err_overrun), 0);

        // Prefix timeout leaves the pressed set untouched.
        send(8'h1D);
        do_ack();
        send(8'hF0);
        for (int i = 0; i < int'(T) - 1; i++) step();
        chk("to_before",    32'(bus.err_timeout), 0);
        chk("to_before_oc", 32'(bus.ocupado), 1);
        step();
        chk("to_pulse",   32'(bus.err_timeout), 1);
        chk("to_ocupado", 32'(bus.ocupado), 0);
        step();
        chk("to_pulse_end", 32'(bus.err_timeout), 0);
        send(8'h1D);
        chk("to_kept_pressed", 32'(bus.cmd_valid), 0);

        // Byte on the expiry cycle is decoded instead of timing out.
        send(8'hF0);
        for (int i = 0; i < int'(T) - 1; i++) step();
        send(8'h1D);
        chk("to_race_timeout", 32'(bus.err_timeout), 0);
        chk("to_race_valid",   32'(bus.cmd_valid), 1);
        chk("to_race_rel",     32'(bus.cmd_release), 1);
        do_ack();

        // Asynchronous reset mid-prefix and while holding a command.
        send(8'hE0);
        chk("ar_pre_oc", 32'(bus.ocupado), 1);
        rst = 1'b0;
        #1;
        chk("ar_pre_oc0", 32'(bus.ocupado), 0);
        step();
        rst = 1'b1;
        send(8'h76);
        chk("ar_pre_code", 32'(bus.cmd_code), 6);
        chk("ar_pre_rel",  32'(bus.cmd_release), 0);
        chk("ar_pre_vld",  32'(bus.cmd_valid), 1);
        rst = 1'b0;
        #1;
        chk("ar_hold_valid", 32'(bus.cmd_valid), 0);
        chk("ar_hold_code",  32'(bus.cmd_code), 0);
        chk("ar_hold_oc",    32'(bus.ocupado), 0);
        step();
        rst = 1'b1;
        send(8'h76);
        chk("ar_after_valid", 32'(bus.cmd_valid), 1);
        chk("ar_after_code",  32'(bus.cmd_code), 6);
        do_ack();

        // Random byte stream against the model, with stray acks outside HOLD.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 5))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = 8'($urandom_range(0, 255));
                default: begin
                    case ($urandom_range(0, 9))
                        0: b = 8'h1D; 1: b = 8'h1B; 2: b = 8'h1C; 3: b = 8'h23;
                        4: b = 8'h5A; 5: b = 8'h76; 6: b = 8'h75; 7: b = 8'h72;
                        8: b = 8'h6B; default: b = 8'h74;
                    endcase
                end
            endcase
            model_byte(b, m_emit, m_code, m_rel);
            send(b);
            chk("rnd_valid", 32'(bus.cmd_valid), 32'(m_emit));
            if (m_emit) begin
                chk("rnd_code", 32'(bus.cmd_code), 32'(m_code));
                chk("rnd_rel",  32'(bus.cmd_release), 32'(m_rel));
                chk("rnd_ini",  32'(bus.inicio_tomadatos), 32'(!m_rel && m_code == 5));
                held_code = bus.cmd_code;
                for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
                    step();
                    chk("rnd_hold", 32'({bus.cmd_valid, bus.cmd_code}), 32'({1'b1, held_code}));
                end
                do_ack();
                chk("rnd_acked", 32'(bus.cmd_valid), 0);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                bus.cmd_ack = 1'($urandom_range(0, 1));
                step();
            end
            bus.cmd_ack = 1'b0;
        end
        chk("rnd_overrun", 32'(bus.err_overrun), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_control_comandos.md
PS2_CONTROL_COMANDOS -- requirements
Module: ps2_control_comandos

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd50000; idle cycles allowed between a prefix byte (E0/F0) and the next byte.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-004 dato  input  8  scan-code byte from the PS/2 receiver; valid only when tick=1.
REQ-005 tick  input  1  one-cycle strobe marking a new dato byte.
REQ-006 cmd_ack  input  1  downstream accepts the current command.
REQ-007 cmd_valid  output  1  command available; held until accepted.
REQ-008 cmd_code  output  3  command: 1 up, 2 down, 3 left, 4 right, 5 enter, 6 escape.
REQ-009 cmd_release  output  1  0 = key make, 1 = key break.
REQ-010 inicio_tomadatos  output  1  one-cycle pulse starting data capture.
REQ-011 ocupado  output  1  high whenever the state is not IDLE.
REQ-012 err_overrun  output  1  sticky; a byte arrived while a command was pending.
REQ-013 err_timeout  output  1  one-cycle pulse on prefix timeout.

Function
REQ-014 FSM states: IDLE, PRE_F0, PRE_E0, PRE_E0F0, HOLD.
REQ-015 IDLE with tick: dato=F0 -> PRE_F0; dato=E0 -> PRE_E0; mapped code -> resolve as make; other -> discard, stay IDLE.
REQ-016 PRE_E0 with tick: F0 -> PRE_E0F0; mapped extended code -> resolve as make; other -> discard, IDLE.
REQ-017 PRE_F0 and PRE_E0F0 with tick: mapped code (normal or extended set, respectively) -> resolve as break; other -> discard, IDLE.
REQ-018 Normal map: 1D->1, 1B->2, 1C->3, 23->4, 5A->5, 76->6; extended map (after E0): 75->1, 72->2, 6B->3, 74->4.
REQ-019 A 6-bit pressed vector, one bit per cmd_code 1..6; resolve make sets the bit, resolve break clears it.
REQ-020 Resolve make of a code whose bit is already set (typematic repeat) emits nothing and returns to IDLE.
REQ-021 Resolve break of a code whose bit is clear still emits the release command.
REQ-022 Emitting: in the cycle after the final byte's tick, cmd_valid=1, cmd_code and cmd_release are driven, and the state is HOLD; latency is one cycle.
REQ-023 inicio_tomadatos pulses in the same cycle cmd_valid first rises, only for cmd_code=5 make.
REQ-024 In HOLD, cmd_valid, cmd_code and cmd_release stay constant until cmd_ack=1 is sampled; the next cycle cmd_valid=0 and the state is IDLE.
REQ-025 cmd_ack outside HOLD is ignored.
REQ-026 A tick in HOLD drops the byte and sets err_overrun; the flag clears only on reset. A tick in the ack cycle is also dropped.
REQ-027 Prefix timer: it clears on entry to any PRE_* state and counts each cycle without tick; at TIMEOUT_CYC-1 the FSM returns to IDLE, pulses err_timeout for one cycle, and leaves the pressed vector unchanged.
REQ-028 A tick in the same cycle the timer expires is processed as the next byte; no timeout fires.
REQ-029 E0 received in PRE_E0, or F0 received in PRE_F0/PRE_E0F0, discards the sequence and returns to IDLE.

Reset
REQ-030 On rst=0, asynchronously: state IDLE, pressed vector 0, timer 0, and all outputs 0 (cmd_valid, cmd_code=3'd0, cmd_release, inicio_tomadatos, ocupado, err_overrun, err_timeout).
REQ-031 Reset in mid-sequence or in HOLD drops the pending command; the first tick after release is decoded from IDLE.

Verification
REQ-032 Ticks 1D, then F0,1D, ack each -> commands (1,make), then (1,release); pressed bit 1 ends at 0.
REQ-033 Tick 5A -> one cycle later cmd_valid=1, cmd_code=5, inicio_tomadatos=1 for exactly one cycle; holding ack low for 10 cycles keeps cmd_valid=1.
REQ-034 Ticks E0,6B, then E0,F0,6B -> (3,make), then (3,release); tick 1D repeated twice without break -> only one command.
REQ-035 Tick 1C with no ack, then tick 23 -> err_overrun=1 and stays 1; only (3,make) is ever presented.
REQ-036 Tick F0, then no tick for TIMEOUT_CYC cycles -> err_timeout pulse, state IDLE, ocupado=0.
REQ-037 Assert rst in PRE_E0 and in HOLD -> all outputs 0 immediately; next tick 76 -> (6,make).
